// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM states, PC constants
// and the {pc, instr} fetch-queue entry.
package if_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      ISSUE  = 2'd1,
      UPDATE = 2'd2,
      STALL  = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam logic [31:0] PC_INC           = 32'd4;
   localparam int          ENTRY_W          = 64;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_ctrl_queue.sv
// Synchronous fetch FIFO of {pc, instr} entries with flush. When empty the head
// outputs keep showing the last entry that was presented.
module if_queue
   import if_fetch_ctrl_pkg::*;
#(
   parameter  int Q_DEPTH = 2,
   localparam int CNT_W   = $clog2(Q_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  fetch_entry_t     push_data_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output fetch_entry_t     head_o,
   output logic             head_valid_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int               PTR_W    = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(Q_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(Q_DEPTH);

   fetch_entry_t     mem_q [Q_DEPTH];
   fetch_entry_t     last_q;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign head_valid_o = (count_q != '0);
   assign do_pop       = pop_i && head_valid_o;
   assign do_push      = push_i && ((count_q != FULL_CNT) || do_pop);
   assign head_o       = head_valid_o ? mem_q[rd_ptr_q] : last_q;
   assign count_o      = count_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
         if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
         if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
         else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         last_q   <= head_o;
      end
   end

   // Storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns PC advance, issues one fetch per two cycles and
// queues {pc, instr} for decode; redirects flush the queue and reload the PC.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          Q_DEPTH  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_cur,
   output logic        pc_ld,
   output logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redir_valid,
   input  logic [31:0] redir_target,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   localparam int               CNT_W    = $clog2(Q_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(Q_DEPTH);

   fetch_state_e     state_q, state_d;
   logic             pc_ld_q, pc_ld_d;
   logic [31:0]      pc_next_q, pc_next_d;
   logic             push, pop, flush;
   fetch_entry_t     push_entry, head;
   logic             head_valid;
   logic [CNT_W-1:0] count, count_after_pop;

   assign pop             = head_valid && if_ready;
   assign count_after_pop = count - CNT_W'(pop);
   assign push_entry      = '{pc: pc_cur, instr: imem_rdata};

   if_queue #(.Q_DEPTH(Q_DEPTH)) u_queue (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push),
      .push_data_i  (push_entry),
      .pop_i        (pop),
      .flush_i      (flush),
      .head_o       (head),
      .head_valid_o (head_valid),
      .count_o      (count)
   );

   // Every entry into UPDATE loads the PC; a redirect outranks everything but BOOT.
   always_comb begin
      state_d   = state_q;
      pc_ld_d   = 1'b0;
      pc_next_d = pc_next_q;
      push      = 1'b0;
      flush     = 1'b0;
      if ((state_q != BOOT) && redir_valid) begin
         flush     = 1'b1;
         pc_ld_d   = 1'b1;
         pc_next_d = align_word(redir_target);
         state_d   = UPDATE;
      end else begin
         case (state_q)
            BOOT: begin
               pc_ld_d   = 1'b1;
               pc_next_d = RESET_PC;
               state_d   = UPDATE;
            end
            ISSUE: begin
               if (imem_ack) begin
                  push      = 1'b1;
                  pc_ld_d   = 1'b1;
                  pc_next_d = pc_cur + PC_INC;
                  state_d   = UPDATE;
               end
            end
            UPDATE:  state_d = (count_after_pop == FULL_CNT) ? STALL : ISSUE;
            STALL:   if (count_after_pop < FULL_CNT) state_d = ISSUE;
            default: state_d = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= BOOT;
         pc_ld_q   <= 1'b0;
         pc_next_q <= RESET_PC;
      end else begin
         state_q   <= state_d;
         pc_ld_q   <= pc_ld_d;
         pc_next_q <= pc_next_d;
      end
   end

   assign pc_ld     = pc_ld_q;
   assign pc_next   = pc_next_q;
   assign imem_req  = (state_q == ISSUE);
   assign imem_addr = imem_req ? pc_cur : '0;
   assign if_valid  = head_valid;
   assign if_instr  = head.instr;
   assign if_pc     = head.pc;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: behavioural fetch model with a queue, an
// external PC register, directed scenarios and a randomized run.
module tb_if_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam int          QD       = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pcReg;
   logic        pc_ld, imem_req, if_valid;
   logic [31:0] pc_next, imem_addr, if_instr, if_pc, imem_rdata;
   logic        ackIn = 1'b0, redirIn = 1'b0, readyIn = 1'b0;
   logic [31:0] tgtIn = '0;

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   // Behavioural model state
   logic [63:0] mQ[$];
   logic [63:0] mLast;
   logic        mBoot, mLoad, mFetch;
   logic [31:0] mNext;
   logic [31:0] popLog[$];
   int          popCycle[$];

   if_fetch_ctrl #(.RESET_PC(RESET_PC), .Q_DEPTH(QD)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_cur       (pcReg),
      .pc_ld        (pc_ld),
      .pc_next      (pc_next),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (ackIn),
      .imem_rdata   (imem_rdata),
      .redir_valid  (redirIn),
      .redir_target (tgtIn),
      .if_valid     (if_valid),
      .if_ready     (readyIn),
      .if_instr     (if_instr),
      .if_pc        (if_pc)
   );

   always #5 clk = ~clk;

   // External PC register captures on the negedge of the pc_ld cycle.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n)     pcReg <= 32'h0;
      else if (pc_ld) pcReg <= pc_next;
   end

   assign imem_rdata = pcReg ^ 32'h0000_FFFF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic modelReset();
      mQ.delete();
      mLast  = '0;
      mBoot  = 1'b1;
      mLoad  = 1'b0;
      mFetch = 1'b0;
      mNext  = RESET_PC;
   endtask

   // One clock of the fetch rules, evaluated with the inputs seen just before the edge.
   task automatic modelStep();
      cycle++;
      if (mQ.size() > 0) mLast = mQ[0];
      if (mBoot) begin
         mBoot = 1'b0;
         mLoad = 1'b1;
         mNext = RESET_PC;
      end else begin
         if (mQ.size() > 0 && readyIn) begin
            popLog.push_back(mQ[0][63:32]);
            popCycle.push_back(cycle);
            mQ.delete(0);
         end
         if (redirIn) begin
            mQ.delete();
            mLoad  = 1'b1;
            mFetch = 1'b0;
            mNext  = {tgtIn[31:2], 2'b00};
         end else if (mLoad) begin
            mLoad  = 1'b0;
            mFetch = (mQ.size() < QD);
         end else if (mFetch) begin
            if (ackIn) begin
               mQ.push_back({pcReg, pcReg ^ 32'h0000_FFFF});
               mLoad  = 1'b1;
               mNext  = pcReg + 32'd4;
               mFetch = 1'b0;
            end
         end else begin
            mFetch = (mQ.size() < QD);
         end
      end
   endtask

   task automatic checkOutput();
      logic [63:0] headExp;
      headExp = (mQ.size() > 0) ? mQ[0] : mLast;
      chk("pc_ld",    32'(pc_ld),    32'(mLoad));
      chk("pc_next",  pc_next,       mNext);
      chk("imem_req", 32'(imem_req), 32'(mFetch));
      if (mFetch) chk("imem_addr", imem_addr, pcReg);
      chk("if_valid", 32'(if_valid), 32'(mQ.size() > 0));
      chk("if_pc",    if_pc,         headExp[63:32]);
      chk("if_instr", if_instr,      headExp[31:0]);
   endtask

   task automatic applyStimulus(input logic ack, input logic redir,
                                input logic [31:0] tgt, input logic ready);
      ackIn   = ack;
      redirIn = redir;
      tgtIn   = tgt;
      readyIn = ready;
   endtask

   task automatic step();
      @(posedge clk);
      modelStep();
      #1;
      checkOutput();
   endtask

   task automatic checkResetValues(input string tag);
      chk({tag, ".pc_ld"},    32'(pc_ld),    32'd0);
      chk({tag, ".pc_next"},  pc_next,       RESET_PC);
      chk({tag, ".imem_req"}, 32'(imem_req), 32'd0);
      chk({tag, ".if_valid"}, 32'(if_valid), 32'd0);
      chk({tag, ".if_instr"}, if_instr,      32'd0);
      chk({tag, ".if_pc"},    if_pc,         32'd0);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (2) @(negedge clk);
      checkResetValues("reset");
      rst_n = 1'b1;
      modelReset();
   endtask

   // Asynchronous reset asserted away from the clock edge while a fetch is pending.
   task automatic midReset();
      rst_n = 1'b0;
      #1;
      checkResetValues("midReset");
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      modelReset();
   endtask

   initial begin
      #10_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] simulation did not terminate");
   end

   initial begin
      modelReset();

      // Sequential fetch with zero-wait memory and an always-ready decode.
      doReset();
      popLog.delete();
      popCycle.delete();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      step();
      chk("boot.pc_ld",   32'(pc_ld), 32'd1);
      chk("boot.pc_next", pc_next,    32'h0040_0000);
      step();
      chk("firstReq.req",  32'(imem_req), 32'd1);
      chk("firstReq.addr", imem_addr,     32'h0040_0000);
      repeat (10) step();
      chk("seq.popCount", 32'(popLog.size() >= 3), 32'd1);
      if (popLog.size() >= 3) begin
         chk("seq.pc0", popLog[0], 32'h0040_0000);
         chk("seq.pc1", popLog[1], 32'h0040_0004);
         chk("seq.pc2", popLog[2], 32'h0040_0008);
         chk("seq.gap1", 32'(popCycle[1] - popCycle[0]), 32'd2);
         chk("seq.gap2", 32'(popCycle[2] - popCycle[1]), 32'd2);
      end

      // Back-pressure fills the queue, then one pop restarts fetching.
      doReset();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      repeat (10) step();
      chk("stall.req",   32'(imem_req), 32'd0);
      chk("stall.valid", 32'(if_valid), 32'd1);
      chk("stall.pc",    if_pc,         32'h0040_0000);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      step();
      chk("resume.req",  32'(imem_req), 32'd1);
      chk("resume.addr", imem_addr,     32'h0040_0008);

      // Redirect during ISSUE with an unaligned target.
      applyStimulus(1'b0, 1'b1, 32'h0040_0103, 1'b0);
      step();
      chk("redir.pc_ld",   32'(pc_ld),    32'd1);
      chk("redir.pc_next", pc_next,       32'h0040_0100);
      chk("redir.valid",   32'(if_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      step();
      chk("redir.addr", imem_addr, 32'h0040_0100);

      // Redirect and ack in the same cycle: fetched word dropped.
      applyStimulus(1'b1, 1'b1, 32'h0040_0200, 1'b0);
      step();
      chk("redirAck.valid",   32'(if_valid), 32'd0);
      chk("redirAck.pc_next", pc_next,       32'h0040_0200);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      step();
      step();
      chk("redirAck.headValid", 32'(if_valid), 32'd1);
      chk("redirAck.headPc",    if_pc,         32'h0040_0200);
      chk("redirAck.headInstr", if_instr,      32'h0040_FDFF);

      // PC wrap at the top of the address space.
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      step();
      chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      step();
      chk("wrap.pc_next", pc_next,  32'h0000_0000);
      chk("wrap.headPc",  if_pc,    32'hFFFF_FFFC);
      chk("wrap.instr",   if_instr, 32'hFFFF_0003);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      step();
      chk("midReset.pre", 32'(imem_req), 32'd1);
      midReset();

      // Randomized traffic with occasional asynchronous resets mid-fetch.
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom % 3) != 0, ($urandom % 16) == 0,
                       $urandom, ($urandom % 2) == 1);
         step();
         if ((i % 400) == 399 && mFetch) midReset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
